// File: rtl/mem_sys.sv
// mem_sys: 256x8 responder memory for the memory-system tester.
// After reset every location is swept to INIT_VAL, then `ready` rises.
// Writes go through a one-stage pipeline; reads forward the pending write
// and can be corrupted by a stuck-bit injector on one chosen address.
`timescale 1ns/1ps

module mem_sys #(
    parameter int             AW       = 8,
    parameter int             DW       = 8,
    parameter logic [DW-1:0]  INIT_VAL = 8'hA5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wra,
    input  logic [DW-1:0] wrd,
    input  logic [AW-1:0] rda,
    output logic [DW-1:0] rdd,
    input  logic          fault_en,
    input  logic [AW-1:0] fault_addr,
    input  logic [DW-1:0] fault_mask,
    input  logic [DW-1:0] fault_val,
    output logic          ready,
    output logic [15:0]   wr_count
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_addr_reg;

    logic          wp_v_reg;
    logic [AW-1:0] wp_addr_reg;
    logic [DW-1:0] wp_data_reg;
    logic [15:0]   wr_count_reg;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_q_reg;

    // Read-side side-band captured alongside the array read so the output
    // mux sits after the block RAM's own output register.
    logic          rd_valid_reg;
    logic          fwd_hit_reg;
    logic [DW-1:0] fwd_data_reg;
    logic          fault_hit_reg;
    logic [DW-1:0] fault_mask_reg;
    logic [DW-1:0] fault_val_reg;

    logic [DW-1:0] raw_data;
    logic [DW-1:0] faulted;

    // Next state: leave CLEAR once the last location has been written.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_addr_reg == '1) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // State register and clear-sweep address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_CLEAR) clr_addr_reg <= clr_addr_reg + 1'b1;
        end
    end

    // Single array write port: sweep during CLEAR, pipeline commit in RUN.
    // Reset suppresses the write so a pending write is dropped, not committed.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wp_addr_reg;
        mem_wd = wp_data_reg;
        if (!reset) begin
            if (state_reg == ST_CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr_addr_reg;
                mem_wd = INIT_VAL;
            end else if (wp_v_reg) begin
                mem_we = 1'b1;
            end
        end
    end

    // Array write.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Array read; returns pre-commit contents on a same-edge collision.
    always_ff @(posedge clock) begin
        mem_q_reg <= mem[rda];
    end

    // Write pipeline capture and saturating commit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_v_reg     <= 1'b0;
            wp_addr_reg  <= '0;
            wp_data_reg  <= '0;
            wr_count_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            wp_v_reg <= we;
            if (we) begin
                wp_addr_reg <= wra;
                wp_data_reg <= wrd;
            end
            if (wp_v_reg && (wr_count_reg != 16'hFFFF))
                wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    // Forwarding and fault decisions registered with the read address.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_reg   <= 1'b0;
            fwd_hit_reg    <= 1'b0;
            fwd_data_reg   <= '0;
            fault_hit_reg  <= 1'b0;
            fault_mask_reg <= '0;
            fault_val_reg  <= '0;
        end else begin
            rd_valid_reg   <= (state_reg == ST_RUN);
            fwd_hit_reg    <= wp_v_reg && (wp_addr_reg == rda);
            fwd_data_reg   <= wp_data_reg;
            fault_hit_reg  <= fault_en && (fault_addr == rda);
            fault_mask_reg <= fault_mask;
            fault_val_reg  <= fault_val;
        end
    end

    assign raw_data = fwd_hit_reg ? fwd_data_reg : mem_q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_fault
            assign faulted[gi] = (fault_hit_reg && fault_mask_reg[gi]) ?
                                 fault_val_reg[gi] : raw_data[gi];
        end
    endgenerate

    assign rdd      = rd_valid_reg ? faulted : '0;
    assign ready    = (state_reg == ST_RUN);
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_mem_sys.sv
// Self-checking bench for mem_sys: constant vector table, randomized traffic
// against a behavioural memory model, and multi-cycle reset/clear sequences.
`timescale 1ns/1ps

module tb_mem_sys;

    logic        clock = 1'b0;
    logic        reset;
    logic        we;
    logic [7:0]  wra, wrd, rda;
    logic [7:0]  rdd;
    logic        fault_en;
    logic [7:0]  fault_addr, fault_mask, fault_val;
    logic        ready;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: stored contents, one pending (not yet visible) write.
    logic [7:0]  m_mem [256];
    bit          p_v;
    logic [7:0]  p_a, p_d;
    int unsigned m_cnt;

    typedef struct {
        bit         w;
        logic [7:0] wa, wd, ra;
        bit         fe;
        logic [7:0] fa, fm, fv;
        logic [7:0] exp_rdd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vt [12];

    mem_sys dut (
        .clock      (clock),
        .reset      (reset),
        .we         (we),
        .wra        (wra),
        .wrd        (wrd),
        .rda        (rda),
        .rdd        (rdd),
        .fault_en   (fault_en),
        .fault_addr (fault_addr),
        .fault_mask (fault_mask),
        .fault_val  (fault_val),
        .ready      (ready),
        .wr_count   (wr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [7:0] wa, wd, ra,
                                input bit fe, input logic [7:0] fa, fm, fv,
                                input logic [7:0] er, input logic [15:0] ec);
        vec_t v;
        v.w = w; v.wa = wa; v.wd = wd; v.ra = ra;
        v.fe = fe; v.fa = fa; v.fm = fm; v.fv = fv;
        v.exp_rdd = er; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'hA5;
        p_v   = 1'b0;
        m_cnt = 0;
    endtask

    // One RUN-mode cycle: drive at negedge, predict, check at the next negedge.
    task automatic cyc(input bit w, input logic [7:0] wa, wd, ra,
                       input bit fe, input logic [7:0] fa, fm, fv);
        logic [7:0] raw, e;
        we = w; wra = wa; wrd = wd; rda = ra;
        fault_en = fe; fault_addr = fa; fault_mask = fm; fault_val = fv;
        raw = (p_v && p_a == ra) ? p_d : m_mem[ra];
        e   = (fe && ra == fa) ? ((raw & ~fm) | (fv & fm)) : raw;
        if (p_v) begin
            m_mem[p_a] = p_d;
            if (m_cnt < 65535) m_cnt++;
        end
        p_v = w; p_a = wa; p_d = wd;
        @(posedge clock);
        @(negedge clock);
        $display("cyc we=%0b wra=%h wrd=%h rda=%h fe=%0b rdd=%h wr_count=%0d",
                 w, wa, wd, ra, fe, rdd, wr_count);
        chk("model rdd", 32'(rdd), 32'(e));
        chk("model wr_count", 32'(wr_count), m_cnt);
    endtask

    // Reset has just been released at a negedge; walk the 256-edge sweep
    // while requesting a write that must be dropped.
    task automatic sweep(input logic [7:0] drop_addr);
        we = 1'b1; wra = drop_addr; wrd = 8'h11;
        for (int i = 1; i <= 256; i++) begin
            rda = 8'($urandom_range(0, 255));
            @(posedge clock);
            @(negedge clock);
            chk("sweep ready", 32'(ready), (i == 256) ? 32'd1 : 32'd0);
            if (i < 256) chk("sweep rdd", 32'(rdd), 32'd0);
        end
        $display("sweep done ready=%0b wr_count=%0d", ready, wr_count);
        chk("sweep wr_count", 32'(wr_count), 32'd0);
        we = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wra = '0; wrd = '0; rda = '0;
        fault_en = 1'b0; fault_addr = '0; fault_mask = '0; fault_val = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge clock);
        $display("reset rdd=%h ready=%0b wr_count=%0d", rdd, ready, wr_count);
        chk("reset rdd", 32'(rdd), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        sweep(8'h55);

        // Directed vectors, expectations derived by hand.
        vt[0]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd0);
        vt[1]  = mk(0, 8'h00, 8'h00, 8'h7F, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd0);
        vt[2]  = mk(0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd0);
        vt[3]  = mk(0, 8'h00, 8'h00, 8'h55, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd0);
        vt[4]  = mk(1, 8'h10, 8'h3C, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd0);
        vt[5]  = mk(0, 8'h00, 8'h00, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h3C, 16'd1);
        vt[6]  = mk(0, 8'h00, 8'h00, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h3C, 16'd1);
        vt[7]  = mk(1, 8'h20, 8'hFF, 8'h20, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16'd1);
        vt[8]  = mk(0, 8'h00, 8'h00, 8'h20, 1, 8'h20, 8'h01, 8'h00, 8'hFE, 16'd2);
        vt[9]  = mk(0, 8'h00, 8'h00, 8'h21, 1, 8'h20, 8'h01, 8'h00, 8'hA5, 16'd2);
        vt[10] = mk(0, 8'h00, 8'h00, 8'h20, 0, 8'h20, 8'hFF, 8'h00, 8'hFF, 16'd2);
        vt[11] = mk(0, 8'h00, 8'h00, 8'h20, 1, 8'h20, 8'hF0, 8'h50, 8'h5F, 16'd2);
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].w, vt[i].wa, vt[i].wd, vt[i].ra,
                vt[i].fe, vt[i].fa, vt[i].fm, vt[i].fv);
            chk("vec rdd", 32'(rdd), 32'(vt[i].exp_rdd));
            chk("vec wr_count", 32'(wr_count), 32'(vt[i].exp_cnt));
        end

        // Back-to-back fill with 00 then FF, then read everything back.
        for (int a = 0; a < 256; a++)
            cyc(1, 8'(a), 8'h00, 8'($urandom_range(0, 255)), 0, 8'h00, 8'h00, 8'h00);
        for (int a = 0; a < 256; a++)
            cyc(1, 8'(a), 8'hFF, 8'($urandom_range(0, 255)), 0, 8'h00, 8'h00, 8'h00);
        for (int a = 0; a < 256; a++) begin
            cyc(0, 8'h00, 8'h00, 8'(a), 0, 8'h00, 8'h00, 8'h00);
            chk("bulk read", 32'(rdd), 32'hFF);
        end
        chk("bulk wr_count", 32'(wr_count), 32'd514);

        // Randomized traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));

        // Reset one cycle after a write capture: the write must never land.
        cyc(1, 8'h30, 8'h77, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        reset = 1'b1; we = 1'b0;
        @(negedge clock);
        $display("mid reset ready=%0b wr_count=%0d rdd=%h", ready, wr_count, rdd);
        chk("mid reset ready", 32'(ready), 32'd0);
        chk("mid reset wr_count", 32'(wr_count), 32'd0);
        chk("mid reset rdd", 32'(rdd), 32'd0);
        reset = 1'b0;
        sweep(8'h30);
        cyc(0, 8'h00, 8'h00, 8'h30, 0, 8'h00, 8'h00, 8'h00);
        chk("dropped write", 32'(rdd), 32'hA5);
        cyc(0, 8'h00, 8'h00, 8'h20, 0, 8'h00, 8'h00, 8'h00);
        chk("recleared", 32'(rdd), 32'hA5);
        cyc(0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00);
        chk("recleared top", 32'(rdd), 32'hA5);

        // Saturation of the commit counter.
        we = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            wra = 8'($urandom);
            wrd = 8'($urandom);
            @(posedge clock);
        end
        @(negedge clock);
        we = 1'b0;
        @(posedge clock);
        @(negedge clock);
        $display("saturation wr_count=%h", wr_count);
        chk("saturation wr_count", 32'(wr_count), 32'hFFFF);
        chk("saturation ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
